acc_deshifter_array: RTL and testbench

ACC_DESHIFTER_ARRAY -- requirements
Module: acc_deshifter_array

---
 rtl/acc_deshifter_pkg.sv | 17 +
 rtl/acc_deshifter_array_if.sv | 13 +
 rtl/acc_deshifter_lane.sv | 80 ++++++++
 rtl/acc_deshifter_array.sv | 133 +++++++++++++
 tb/tb_acc_deshifter_array.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_deshifter_pkg.sv
// Shared types and helpers for the bit-serial accumulator deshifter array.
package acc_deshifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/acc_deshifter_array_if.sv
// Registered SRAM write port driven by the deshifter array.
interface acc_deshifter_array_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data;

  modport master (output sram_en, sram_we, sram_addr, sram_data);
  modport slave  (input  sram_en, sram_we, sram_addr, sram_data);
endinterface

// File: rtl/acc_deshifter_lane.sv
// One lane: LSB-first deserialiser, one-entry hold register, rx/wr counters and
// a sticky overflow flag for words that complete while the hold is still full.
module acc_deshifter_lane
  import acc_deshifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] img_size_i,
  input  logic              ser_i,
  input  logic              ser_en_i,
  input  logic              gnt_i,
  output logic              ch_idle_o,
  output logic              full_o,
  output logic              hold_vld_o,
  output logic [DATA_W-1:0] hold_word_o,
  output logic [ADDR_W-1:0] wr_cnt_o,
  output logic              ovf_o
);
  localparam int BW = (DATA_W > 1) ? clog2(DATA_W) : 1;

  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [ADDR_W:0]   rx_cnt_q;
  logic              hold_vld_q;
  logic [DATA_W-1:0] hold_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              ovf_q;
  logic              take, word_done;

  assign full_o    = (rx_cnt_q == ({1'b0, img_size_i} + (ADDR_W+1)'(1)));
  assign ch_idle_o = !run_i || full_o;
  assign take      = !ch_idle_o && ser_en_i;
  assign word_done = take && (bit_cnt_q == BW'(DATA_W-1));

  always_comb begin
    sh_d            = sh_q;
    sh_d[bit_cnt_q] = ser_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      rx_cnt_q   <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (take) begin
        sh_q      <= sh_d;
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
      end
      // A granted hold frees its slot this edge, so a word completing now can land.
      if (word_done) begin
        rx_cnt_q <= rx_cnt_q + (ADDR_W+1)'(1);
        if (hold_vld_q && !gnt_i) begin
          ovf_q <= 1'b1;
        end else begin
          hold_q     <= sh_d;
          hold_vld_q <= 1'b1;
        end
      end else if (gnt_i) begin
        hold_vld_q <= 1'b0;
      end
      if (gnt_i) wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
    end
  end

  assign hold_vld_o  = hold_vld_q;
  assign hold_word_o = hold_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/acc_deshifter_array.sv
// NUM_CH bit-serial lanes feeding one SRAM write port through a round-robin
// arbiter; IDLE/RUN/DRAIN sequencing with a done pulse when the last write lands.
module acc_deshifter_array
  import acc_deshifter_pkg::*;
#(
  parameter  int NUM_CH     = 32,
  parameter  int DATA_W     = 32,
  parameter  int SRAM_DEPTH = 1024,
  localparam int ADDR_W     = clog2(SRAM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_start,
  input  logic [ADDR_W*NUM_CH-1:0] start_addr,
  input  logic [ADDR_W-1:0]        img_size,
  input  logic                     relu_en,
  input  logic [NUM_CH-1:0]        serial_input,
  input  logic [NUM_CH-1:0]        serial_en,
  output logic [NUM_CH-1:0]        ch_idle,
  output logic                     shift_idle,
  output logic                     done,
  output logic [NUM_CH-1:0]        overflow,
  acc_deshifter_array_if.master    sram
);
  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  if (NUM_CH > DATA_W) begin : g_bad_cfg
    $error("acc_deshifter_array: NUM_CH must not exceed DATA_W");
  end

  state_e                         state_q;
  logic                           done_q;
  logic [NUM_CH-1:0][ADDR_W-1:0]  start_addr_q;
  logic [ADDR_W-1:0]              img_q;
  logic                           relu_q;
  logic [CH_W-1:0]                ptr_q;
  logic                           en_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [DATA_W-1:0]              data_q;

  logic                           start, run;
  logic [NUM_CH-1:0]              full, hold_vld, gnt;
  logic [NUM_CH-1:0][DATA_W-1:0]  hold_word;
  logic [NUM_CH-1:0][ADDR_W-1:0]  wr_cnt;
  logic                           gnt_vld;
  logic [CH_W-1:0]                gnt_idx, cand;
  logic [DATA_W-1:0]              wr_word;

  assign start = shift_start && (state_q == ST_IDLE);
  assign run   = (state_q == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    acc_deshifter_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (start),
      .run_i      (run),
      .img_size_i (img_q),
      .ser_i      (serial_input[i]),
      .ser_en_i   (serial_en[i]),
      .gnt_i      (gnt[i]),
      .ch_idle_o  (ch_idle[i]),
      .full_o     (full[i]),
      .hold_vld_o (hold_vld[i]),
      .hold_word_o(hold_word[i]),
      .wr_cnt_o   (wr_cnt[i]),
      .ovf_o      (overflow[i])
    );
  end

  // Round-robin: first pending lane at or after ptr_q (last grant + 1).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
      if (!gnt_vld && hold_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  assign wr_word = hold_word[gnt_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      start_addr_q <= '0;
      img_q        <= '0;
      relu_q       <= 1'b0;
      ptr_q        <= '0;
      en_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      done_q <= 1'b0;
      en_q   <= gnt_vld;
      if (gnt_vld) begin
        addr_q <= start_addr_q[gnt_idx] + wr_cnt[gnt_idx];
        data_q <= (relu_q && wr_word[DATA_W-1]) ? '0 : wr_word;
        ptr_q  <= (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_W'(1);
      end
      case (state_q)
        ST_IDLE: if (shift_start) begin
          start_addr_q <= start_addr;
          img_q        <= img_size;
          relu_q       <= relu_en;
          state_q      <= ST_RUN;
        end
        ST_RUN: if (&full) state_q <= ST_DRAIN;
        // Leave only once the final write has been presented on the port.
        ST_DRAIN: if (!(|hold_vld) && !en_q) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign shift_idle     = (state_q == ST_IDLE);
  assign done           = done_q;
  assign sram.sram_en   = en_q;
  assign sram.sram_we   = en_q;
  assign sram.sram_addr = addr_q;
  assign sram.sram_data = data_q;

endmodule

// File: tb/tb_acc_deshifter_array.sv
// Directed bench for acc_deshifter_array with default parameters (32x32, 1024 words).
module tb_acc_deshifter_array;
  localparam int NC = 32;
  localparam int DW = 32;
  localparam int AW = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             shift_start;
  logic [AW*NC-1:0] start_addr;
  logic [AW-1:0]    img_size;
  logic             relu_en;
  logic [NC-1:0]    serial_input, serial_en;
  logic [NC-1:0]    ch_idle, overflow;
  logic             shift_idle, done;

  acc_deshifter_array_if #(.ADDR_W(AW), .DATA_W(DW)) sram_if ();

  acc_deshifter_array dut (
    .clk         (clk),
    .reset       (reset),
    .shift_start (shift_start),
    .start_addr  (start_addr),
    .img_size    (img_size),
    .relu_en     (relu_en),
    .serial_input(serial_input),
    .serial_en   (serial_en),
    .ch_idle     (ch_idle),
    .shift_idle  (shift_idle),
    .done        (done),
    .overflow    (overflow),
    .sram        (sram_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_total = 0;
  int done_cnt = 0;
  int we_bad = 0;
  int cyc = 0;
  int wlog_a[$];
  int wlog_c[$];
  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] expm [1024];
  logic [DW-1:0] wtab [NC][NC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sram_if.sram_we !== sram_if.sram_en) we_bad++;
    if (sram_if.sram_en === 1'b1) begin
      mem[sram_if.sram_addr] = sram_if.sram_data;
      wlog_a.push_back(int'(sram_if.sram_addr));
      wlog_c.push_back(cyc);
      wr_total++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic prep();
    for (int a = 0; a < 1024; a++) begin
      mem[a]  = 32'hDEADBEEF;
      expm[a] = 32'hDEADBEEF;
    end
    wlog_a.delete();
    wlog_c.delete();
  endtask

  function automatic int mem_errs();
    int e = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== expm[a]) e++;
    return e;
  endfunction

  task automatic start(input int img, input bit relu);
    img_size    = AW'(img);
    relu_en     = relu;
    shift_start = 1'b1;
    @(negedge clk);
    shift_start = 1'b0;
  endtask

  task automatic stream(input int nw, input bit gaps, input bit poke, input int stop_wr);
    int bi[NC];
    int wi[NC];
    int left;
    int w0;
    w0 = wr_total;
    for (int i = 0; i < NC; i++) begin
      bi[i] = 0;
      wi[i] = 0;
    end
    for (int c = 0; c < 20000; c++) begin
      left = 0;
      for (int i = 0; i < NC; i++) begin
        if (wi[i] < nw && (!gaps || $urandom_range(0, 3) != 0)) begin
          serial_en[i]    = 1'b1;
          serial_input[i] = wtab[i][wi[i]][bi[i]];
          bi[i]++;
          if (bi[i] == DW) begin
            bi[i] = 0;
            wi[i]++;
          end
        end else begin
          serial_en[i]    = 1'b0;
          serial_input[i] = 1'($urandom_range(0, 1));
        end
        if (wi[i] < nw) left++;
      end
      // A second start during RUN, with different config, must be ignored.
      if (poke && c == 100) begin
        shift_start = 1'b1;
        start_addr  = '0;
        img_size    = '0;
      end else begin
        shift_start = 1'b0;
      end
      @(negedge clk);
      if (left == 0) break;
      if (stop_wr > 0 && wr_total - w0 >= stop_wr) break;
    end
    serial_en   = '0;
    shift_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base;
    base = done_cnt;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done_cnt != base) break;
    end
    repeat (3) @(negedge clk);
    chk(tag, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic cfg_linear();
    prep();
    for (int i = 0; i < NC; i++) begin
      start_addr[i*AW +: AW] = AW'(i * 32);
      for (int k = 0; k < NC; k++) begin
        wtab[i][k]       = DW'(k);
        expm[i * 32 + k] = DW'(k);
      end
    end
  endtask

  task automatic cfg_wrap();
    prep();
    for (int i = 0; i < NC; i++) begin
      start_addr[i*AW +: AW] = AW'((1020 + 8 * i) % 1024);
      for (int k = 0; k < 8; k++) begin
        wtab[i][k] = DW'(i * 256 + k);
        expm[(1020 + 8 * i + k) % 1024] = DW'(i * 256 + k);
      end
    end
  endtask

  task automatic cfg_relu(input bit relu);
    prep();
    for (int i = 0; i < NC; i++) begin
      start_addr[i*AW +: AW] = AW'(i * 2);
      wtab[i][0]     = 32'hFFFFFFF0;
      wtab[i][1]     = 32'h7FFFFFFF;
      expm[2 * i]    = relu ? 32'h0 : 32'hFFFFFFF0;
      expm[2 * i + 1] = 32'h7FFFFFFF;
    end
  endtask

  initial begin
    int w0, e;
    reset = 1'b1; shift_start = 1'b0; start_addr = '0; img_size = '0;
    relu_en = 1'b0; serial_input = '0; serial_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_shift_idle", 64'(shift_idle), 64'd1);
    chk("rst_ch_idle", 64'(ch_idle), 64'hFFFFFFFF);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_sram_en", 64'(sram_if.sram_en), 64'd0);
    chk("rst_sram_addr", 64'(sram_if.sram_addr), 64'd0);
    chk("rst_sram_data", 64'(sram_if.sram_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full image, all lanes in lockstep.
    cfg_linear();
    w0 = wr_total;
    start(31, 1'b0);
    chk("t1_run_ch_idle", 64'(ch_idle), 64'd0);
    chk("t1_run_shift_idle", 64'(shift_idle), 64'd0);
    stream(32, 1'b0, 1'b0, 0);
    wait_done("t1_done_once");
    chk("t1_writes", 64'(wr_total - w0), 64'd1024);
    chk("t1_mem", 64'(mem_errs()), 64'd0);
    chk("t1_overflow", 64'(overflow), 64'd0);
    chk("t1_idle", 64'(shift_idle), 64'd1);
    e = 0;
    for (int n = 0; n < wlog_a.size() && n < 1024; n++) begin
      if (wlog_a[n] != (n % 32) * 32 + n / 32) e++;
      if (wlog_c[n] != wlog_c[0] + n) e++;
    end
    chk("t1_order", 64'(e), 64'd0);

    // ReLU clamp on and off.
    cfg_relu(1'b1);
    start(1, 1'b1);
    stream(2, 1'b0, 1'b0, 0);
    wait_done("t2_relu_done");
    chk("t2_relu_neg", 64'(mem[0]), 64'h0);
    chk("t2_relu_pos", 64'(mem[1]), 64'h7FFFFFFF);
    chk("t2_relu_mem", 64'(mem_errs()), 64'd0);
    cfg_relu(1'b0);
    start(1, 1'b0);
    stream(2, 1'b0, 1'b0, 0);
    wait_done("t2_norelu_done");
    chk("t2_norelu_neg", 64'(mem[62]), 64'hFFFFFFF0);
    chk("t2_norelu_pos", 64'(mem[63]), 64'h7FFFFFFF);
    chk("t2_norelu_mem", 64'(mem_errs()), 64'd0);

    // Address wrap at the top of the SRAM.
    cfg_wrap();
    start(7, 1'b0);
    stream(8, 1'b0, 1'b0, 0);
    wait_done("t3_done");
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_wrap_%0d", (1020 + k) % 1024), 64'(mem[(1020 + k) % 1024]), 64'(k));
    chk("t3_mem", 64'(mem_errs()), 64'd0);

    // Reset in the middle of RUN, then a clean restart.
    cfg_linear();
    w0 = wr_total;
    start(31, 1'b0);
    stream(32, 1'b0, 1'b0, 10);
    chk("t4_partial", 64'(wr_total - w0 >= 10), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_sram_en", 64'(sram_if.sram_en), 64'd0);
    chk("t4_shift_idle", 64'(shift_idle), 64'd1);
    chk("t4_ch_idle", 64'(ch_idle), 64'hFFFFFFFF);
    chk("t4_sram_addr", 64'(sram_if.sram_addr), 64'd0);
    chk("t4_sram_data", 64'(sram_if.sram_data), 64'd0);
    reset = 1'b0;
    w0 = wr_total;
    repeat (40) @(negedge clk);
    chk("t4_no_wr", 64'(wr_total - w0), 64'd0);
    cfg_wrap();
    start(7, 1'b0);
    stream(8, 1'b0, 1'b0, 0);
    wait_done("t4_restart_done");
    chk("t4_restart_mem", 64'(mem_errs()), 64'd0);

    // Random strobe gaps plus an ignored restart must give the same image as run 1.
    cfg_linear();
    start(31, 1'b0);
    stream(32, 1'b1, 1'b1, 0);
    wait_done("t5_done_once");
    chk("t5_mem", 64'(mem_errs()), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    chk("t5_idle", 64'(shift_idle), 64'd1);

    chk("we_tracks_en", 64'(we_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
